// File: rtl/conv_maxpool2x2_if.sv
// conv_maxpool2x2_if: sample stream into, and pooled stream out of, the 2x2 max-pool stage
interface conv_maxpool2x2_if #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int DW    = 16,
    parameter int NOUT  = (IMG_W / 2) * (IMG_H / 2),
    parameter int IW    = NOUT > 1 ? $clog2(NOUT) : 1
);
    logic          frame_start;
    logic          din_valid;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [IW-1:0] dout_idx;
    logic          frame_done;

    modport master (
        output frame_start, din_valid, din,
        input  dout, dout_valid, dout_idx, frame_done
    );

    modport slave (
        input  frame_start, din_valid, din,
        output dout, dout_valid, dout_idx, frame_done
    );
endinterface

// File: rtl/conv_maxpool2x2.sv
// conv_maxpool2x2: streaming 2x2 stride-2 max pool using a half-width line buffer of pair maxima
module conv_maxpool2x2 #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int DW    = 16
) (
    input logic              clk,
    input logic              rst_n,
    conv_maxpool2x2_if.slave bus
);
    localparam int NOUT = (IMG_W / 2) * (IMG_H / 2);
    localparam int IW   = NOUT > 1 ? $clog2(NOUT) : 1;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int HW   = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;

    logic [CW-1:0] col, c, col_nxt;
    logic [RW-1:0] row, r, row_nxt;
    logic [DW-1:0] hold, pairmax, blockmax;
    logic [DW-1:0] linebuf [IMG_W/2];
    logic [HW-1:0] lbi;
    logic          col_end, row_end, emit, last;

    // frame_start makes the current sample pixel (0,0); compute pair/block maxima for this sample
    always_comb begin
        c        = bus.frame_start ? '0 : col;
        r        = bus.frame_start ? '0 : row;
        col_end  = c == CW'(IMG_W - 1);
        row_end  = r == RW'(IMG_H - 1);
        col_nxt  = col_end ? '0 : c + CW'(1);
        row_nxt  = col_end ? (row_end ? '0 : r + RW'(1)) : r;
        lbi      = HW'(c >> 1);
        pairmax  = bus.din > hold ? bus.din : hold;
        blockmax = linebuf[lbi] > pairmax ? linebuf[lbi] : pairmax;
        emit     = bus.din_valid & c[0] & r[0];
        last     = col_end & row_end;
    end

    // position counters, pair hold, line buffer and registered pooled output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            hold           <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.dout_idx   <= '0;
            for (int i = 0; i < IMG_W / 2; i++) linebuf[i] <= '0;
        end else begin
            bus.dout_valid <= emit;
            bus.frame_done <= emit & last;
            if (emit) bus.dout <= blockmax;
            col <= bus.din_valid ? col_nxt : c;
            row <= bus.din_valid ? row_nxt : r;
            if (bus.din_valid && !c[0]) hold <= bus.din;
            if (bus.din_valid && c[0] && !r[0]) linebuf[lbi] <= pairmax;
            bus.dout_idx <= bus.frame_start ? '0 :
                            !bus.dout_valid ? bus.dout_idx :
                            bus.dout_idx == IW'(NOUT - 1) ? '0 : bus.dout_idx + IW'(1);
        end
    end
endmodule

// File: doc/conv_maxpool2x2.md
Name: conv_maxpool2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the 2D convolution core.
- Consumes the 6x6 map of 16-bit unsigned convolution results in raster order, one value per valid strobe.
- Emits the 3x3 pooled map in raster order, also one value per valid strobe.
- Uses a half-width line buffer of partial maxima, so it never stores a full frame.

Parameters:
- IMG_W, 6, input map width in samples; must be even, at least 2.
- IMG_H, 6, input map height in rows; must be even, at least 2.
- DW, 16, sample width; samples are unsigned.

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst_n  input  1  synchronous, active-low reset.
- frame_start  input  1  synchronous, active-high restart of the frame counters; abandons any partial frame.
- din_valid  input  1  din carries a sample this cycle (driven from the conv core's output strobe).
- din  input  DW  conv result, unsigned.
- dout  output  DW  pooled maximum.
- dout_valid  output  1  one-cycle pulse: dout holds a pooled value.
- dout_idx  output  clog2((IMG_W/2)*(IMG_H/2))  raster index of the current dout, from 0 to 8 at defaults.
- frame_done  output  1  one-cycle pulse, coincident with the last dout_valid of a frame.

Behaviour:
- Reset: on a clk edge with rst_n=0, clear col, row, hold register, line buffer and dout_idx; dout=0, dout_valid=0, frame_done=0. Reset has priority over every other input.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. They advance only on cycles with din_valid=1. col wraps to 0 and increments row; after (IMG_W-1, IMG_H-1) both wrap to 0.
- Gaps: din_valid may drop for any number of cycles. State holds and no output is produced.
- Even col: hold <= din.
- Odd col: pairmax = max(hold, din), unsigned compare.
  - Even row: linebuf[col>>1] <= pairmax. No output.
  - Odd row: on the next edge, dout <= max(linebuf[col>>1], pairmax) and dout_valid <= 1.
- dout_idx: index of the value being emitted; increments after each emission and wraps to 0 after the final one.
- Latency: exactly 1 clk from accepting the bottom-right sample of a 2x2 block to dout_valid.
- Holding values: dout_valid and frame_done are high for a single cycle only. dout holds its last value between pulses.
- Equality: when compared values are equal, either one may be selected, since the output value is identical.
- frame_done: asserted in the same cycle as the dout_valid for the block at row IMG_H-1, col IMG_W-1.
- Back-to-back frames: a sample may arrive in the cycle immediately after the last sample of the previous frame and is taken as pixel (0,0) of the next frame. No idle cycle is required.
- frame_start=1 (with rst_n=1): clear col, row and dout_idx. Do not clear line buffer contents, because they are always rewritten before being read.
  - If din_valid=1 in the same cycle, that sample is processed as pixel (0,0).
  - A dout_valid already scheduled from the previous cycle still fires.
- Reset mid-frame: the partial frame is discarded. The next accepted sample is pixel (0,0).
- No arithmetic beyond comparison: no overflow is possible, and dout width equals din width.
- Only even IMG_W and IMG_H are legal. The bench asserts this at elaboration.

Test Plan:
- Ramp: din = 0..35 on 36 consecutive cycles -> dout = 7, 9, 11, 19, 21, 23, 31, 33, 35 with dout_idx 0..8. frame_done occurs with 35. The first dout_valid comes 1 cycle after sample 7.
- Descending: din = 35..0 -> dout = 35, 33, 31, 23, 21, 19, 11, 9, 7. Each maximum is in the top-left of its block, which checks the line-buffer path.
- Gapped input: the ramp with din_valid high every third cycle -> the same 9 values. Each dout_valid arrives exactly 1 cycle after the accepting edge.
- Unsigned compare: a block containing {0x7FFF, 0x8000, 0x0001, 0xFFFE} -> 0xFFFE. An all-0xFFFF frame -> nine 0xFFFF outputs.
- Abort and restart:
  - rst_n=0 for 1 cycle after 20 ramp samples, then a full ramp -> exactly 9 outputs, 7..35 as in the ramp case, and frame_done once.
  - The same sequence using frame_start after 10 samples -> the same result.
  - frame_start together with din_valid -> that sample is used as pixel (0,0).
- Back-to-back: two ramp frames with no idle cycles between them -> 18 outputs. frame_done pulses at output 9 and output 18, and dout_idx wraps to 0.
